// File: rtl/systolic_pkg.sv
// Shared constants, sequencer state encoding and beat slicing for the systolic feed path.
package systolic_pkg;

    localparam int N          = 4;
    localparam int DATA_W     = 16;
    localparam int BEAT_W     = N * N * DATA_W;
    localparam int BEAT_BYTES = BEAT_W / 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_REQ_W,
        ST_WAIT_W,
        ST_REQ_X,
        ST_WAIT_X,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    // Element (kk, r) of a 256-bit beat: kk selects the k offset, r the row/column.
    function automatic logic [DATA_W-1:0] beat_slice(input logic [BEAT_W-1:0] beat,
                                                     input int kk, input int r);
        return beat[DATA_W*(N*kk + r) +: DATA_W];
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_skew_pipe.sv
// Per-lane delay chain: lane r is delayed by r enabled cycles, lane 0 passes straight through.
module skew_pipe #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [LANES*WIDTH-1:0] din,
    output logic [LANES*WIDTH-1:0] dout
);

    assign dout[WIDTH-1:0] = din[WIDTH-1:0];

    for (genvar gi = 1; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] stage_reg [0:gi-1];

        // Shifting only on en keeps the wavefront aligned across fetch stalls.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < gi; s++) begin
                    stage_reg[s] <= '0;
                end
            end else if (en) begin
                stage_reg[0] <= din[gi*WIDTH +: WIDTH];
                for (int s = 1; s < gi; s++) begin
                    stage_reg[s] <= stage_reg[s-1];
                end
            end
        end

        assign dout[gi*WIDTH +: WIDTH] = stage_reg[gi-1];
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Fetches W/X tiles one k-block at a time over the DMA port and feeds the 4x4 array with skew.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = systolic_pkg::N,
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      w_addr,
    input  logic [CNT_W-1:0]      x_addr,
    input  logic [CNT_W-1:0]      k_dim,
    input  logic [CNT_W-1:0]      x_stride,
    output logic [CNT_W-1:0]      dma_addr,
    output logic                  dma_re,
    input  logic                  dma_req_ready,
    input  logic                  dma_resp_valid,
    input  logic [N*N*DATA_W-1:0] dma_rdata,
    output logic                  clear_acc,
    output logic                  en,
    output logic [N*DATA_W-1:0]   a_left,
    output logic [N*DATA_W-1:0]   b_top,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      busy_cycles,
    output logic [CNT_W-1:0]      compute_cycles,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      dma_req_count
);

    localparam int KK_W    = $clog2(N);
    localparam int DRAIN_W = $clog2(2*N);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2*N - 2);
    localparam logic [KK_W-1:0]    KK_LAST    = KK_W'(N - 1);

    feed_state_t               state_reg;
    logic [CNT_W-1:0]          k_dim_reg;
    logic [CNT_W-1:0]          kb_reg;
    logic [CNT_W-1:0]          t_reg;
    logic [KK_W-1:0]           kk_reg;
    logic [DRAIN_W-1:0]        drain_cnt_reg;
    logic [CNT_W-1:0]          w_ptr_reg;
    logic [CNT_W-1:0]          x_ptr_reg;
    logic [CNT_W-1:0]          x_stride_reg;
    logic [N*N*DATA_W-1:0]     w_beat_reg;
    logic [N*N*DATA_W-1:0]     x_beat_reg;
    logic                      done_reg;
    logic [CNT_W-1:0]          busy_cycles_reg;
    logic [CNT_W-1:0]          compute_cycles_reg;
    logic [CNT_W-1:0]          stall_cycles_reg;
    logic [CNT_W-1:0]          dma_req_count_reg;

    logic [CNT_W:0]            kb_sum;
    logic [CNT_W-1:0]          kb_next;
    logic                      fetching;
    logic                      req_fire;
    logic                      feed_live;
    logic [N*DATA_W-1:0]       a_feed;
    logic [N*DATA_W-1:0]       b_feed;

    // Widened by one bit so k_dim near 2^CNT_W does not wrap the round-up.
    assign kb_sum  = {1'b0, k_dim} + (CNT_W+1)'(N - 1);
    assign kb_next = CNT_W'(kb_sum >> KK_W);

    assign fetching = (state_reg == ST_REQ_W) || (state_reg == ST_WAIT_W) ||
                      (state_reg == ST_REQ_X) || (state_reg == ST_WAIT_X);

    // Dropping on reset itself lets the request vanish before the state register clears.
    assign dma_re   = ((state_reg == ST_REQ_W) || (state_reg == ST_REQ_X)) && !reset;
    assign dma_addr = (state_reg == ST_REQ_W) ? w_ptr_reg :
                      (state_reg == ST_REQ_X) ? x_ptr_reg : '0;
    assign req_fire = dma_re && dma_req_ready;

    assign clear_acc = (state_reg == ST_CLEAR);
    assign en        = (state_reg == ST_FEED) || (state_reg == ST_DRAIN);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;

    assign busy_cycles    = busy_cycles_reg;
    assign compute_cycles = compute_cycles_reg;
    assign stall_cycles   = stall_cycles_reg;
    assign dma_req_count  = dma_req_count_reg;

    // Global k index of the current slice is {t, kk}; slices past k_dim feed zeros.
    assign feed_live = (state_reg == ST_FEED) &&
                       ({t_reg, kk_reg} < {{KK_W{1'b0}}, k_dim_reg});

    for (genvar gi = 0; gi < N; gi++) begin : g_feed
        assign a_feed[gi*DATA_W +: DATA_W] =
            feed_live ? beat_slice(w_beat_reg, int'(kk_reg), gi) : '0;
        assign b_feed[gi*DATA_W +: DATA_W] =
            feed_live ? beat_slice(x_beat_reg, int'(kk_reg), gi) : '0;
    end

    skew_pipe #(.LANES(N), .WIDTH(DATA_W)) u_skew_a (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .din   (a_feed),
        .dout  (a_left)
    );

    skew_pipe #(.LANES(N), .WIDTH(DATA_W)) u_skew_b (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .din   (b_feed),
        .dout  (b_top)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            k_dim_reg          <= '0;
            kb_reg             <= '0;
            t_reg              <= '0;
            kk_reg             <= '0;
            drain_cnt_reg      <= '0;
            w_ptr_reg          <= '0;
            x_ptr_reg          <= '0;
            x_stride_reg       <= '0;
            w_beat_reg         <= '0;
            x_beat_reg         <= '0;
            done_reg           <= 1'b0;
            busy_cycles_reg    <= '0;
            compute_cycles_reg <= '0;
            stall_cycles_reg   <= '0;
            dma_req_count_reg  <= '0;
        end else begin
            if (state_reg != ST_IDLE) busy_cycles_reg <= busy_cycles_reg + CNT_W'(1);
            if (state_reg == ST_FEED) compute_cycles_reg <= compute_cycles_reg + CNT_W'(1);
            if (fetching)             stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            if (req_fire)             dma_req_count_reg <= dma_req_count_reg + CNT_W'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        k_dim_reg          <= k_dim;
                        kb_reg             <= kb_next;
                        t_reg              <= '0;
                        kk_reg             <= '0;
                        w_ptr_reg          <= w_addr;
                        x_ptr_reg          <= x_addr;
                        x_stride_reg       <= x_stride;
                        done_reg           <= 1'b0;
                        busy_cycles_reg    <= '0;
                        compute_cycles_reg <= '0;
                        stall_cycles_reg   <= '0;
                        dma_req_count_reg  <= '0;
                        state_reg          <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_reg <= (kb_reg == '0) ? ST_DONE : ST_REQ_W;
                end
                ST_REQ_W: begin
                    if (dma_req_ready) state_reg <= ST_WAIT_W;
                end
                ST_WAIT_W: begin
                    if (dma_resp_valid) begin
                        w_beat_reg <= dma_rdata;
                        state_reg  <= ST_REQ_X;
                    end
                end
                ST_REQ_X: begin
                    if (dma_req_ready) state_reg <= ST_WAIT_X;
                end
                ST_WAIT_X: begin
                    if (dma_resp_valid) begin
                        x_beat_reg <= dma_rdata;
                        kk_reg     <= '0;
                        state_reg  <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    kk_reg <= kk_reg + KK_W'(1);
                    if (kk_reg == KK_LAST) begin
                        t_reg     <= t_reg + CNT_W'(1);
                        w_ptr_reg <= w_ptr_reg + CNT_W'(BEAT_BYTES);
                        x_ptr_reg <= x_ptr_reg + x_stride_reg;
                        if (t_reg + CNT_W'(1) < kb_reg) begin
                            state_reg <= ST_REQ_W;
                        end else begin
                            drain_cnt_reg <= '0;
                            state_reg     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
                    if (drain_cnt_reg == DRAIN_LAST) state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Drives systolic_feed_ctrl against a DMA responder and a behavioural 4x4 output-stationary array,
// and compares the accumulated products with a plain matrix product.
module tb_systolic_feed_ctrl;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [31:0]  w_addr, x_addr, k_dim, x_stride;
    logic [31:0]  dma_addr;
    logic         dma_re, dma_req_ready, dma_resp_valid;
    logic [255:0] dma_rdata;
    logic         clear_acc, en, busy, done;
    logic [63:0]  a_left, b_top;
    logic [31:0]  busy_cycles, compute_cycles, stall_cycles, dma_req_count;

    int vectors = 0;
    int miscompares = 0;

    int  wm [4][16];
    int  xm [16][4];
    logic [31:0] obs_addr [$];
    int  extra_stall, addr_glitch;
    bit  timed_out, aborted, done_after_start;
    logic mid_busy, mid_re, mid_en;

    logic signed [15:0] a_pipe [4][4];
    logic signed [15:0] b_pipe [4][4];
    longint             acc    [4][4];

    always #5 clk = ~clk;

    systolic_feed_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .w_addr         (w_addr),
        .x_addr         (x_addr),
        .k_dim          (k_dim),
        .x_stride       (x_stride),
        .dma_addr       (dma_addr),
        .dma_re         (dma_re),
        .dma_req_ready  (dma_req_ready),
        .dma_resp_valid (dma_resp_valid),
        .dma_rdata      (dma_rdata),
        .clear_acc      (clear_acc),
        .en             (en),
        .a_left         (a_left),
        .b_top          (b_top),
        .busy           (busy),
        .done           (done),
        .busy_cycles    (busy_cycles),
        .compute_cycles (compute_cycles),
        .stall_cycles   (stall_cycles),
        .dma_req_count  (dma_req_count)
    );

    function automatic logic signed [15:0] a_at(input int i, input int j);
        if (j == 0) return $signed(a_left[16*i +: 16]);
        return a_pipe[i][j-1];
    endfunction

    function automatic logic signed [15:0] b_at(input int i, input int j);
        if (i == 0) return $signed(b_top[16*j +: 16]);
        return b_pipe[i-1][j];
    endfunction

    // Output-stationary array: a flows right, b flows down, PE(i,j) accumulates a*b.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (reset) begin
                    acc[i][j]    <= 0;
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                end else if (clear_acc) begin
                    acc[i][j] <= 0;
                end else if (en) begin
                    acc[i][j]    <= acc[i][j] + longint'(a_at(i, j)) * longint'(b_at(i, j));
                    a_pipe[i][j] <= a_at(i, j);
                    b_pipe[i][j] <= b_at(i, j);
                end
            end
        end
    end

    function automatic longint exp_c(input int i, input int j, input int kd);
        longint s = 0;
        for (int k = 0; k < kd && k < 16; k++) s += longint'(wm[i][k]) * longint'(xm[k][j]);
        return s;
    endfunction

    function automatic int exp_busy(input int kd, input int extra);
        int kb = (kd + 3) / 4;
        if (kb == 0) return 2;
        return 2 + 8*kb + 7 + extra;
    endfunction

    function automatic logic [255:0] make_beat(input bit is_w, input int t);
        logic [255:0] b = '0;
        for (int kk = 0; kk < 4; kk++) begin
            for (int r = 0; r < 4; r++) begin
                int k = 4*t + kk;
                int v = 0;
                if (k < 16) v = is_w ? wm[r][k] : xm[k][r];
                b[16*(4*kk + r) +: 16] = 16'(v);
            end
        end
        return b;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                wm[r][k] = int'($urandom_range(200)) - 100;
                xm[k][r] = int'($urandom_range(200)) - 100;
            end
        end
    endtask

    task automatic run_job(input int kd, input logic [31:0] wa, input logic [31:0] xa,
                           input logic [31:0] xs, input int first_stall, input int first_delay,
                           input bit rand_dma, input bit poke_start, input bit reset_mid);
        int cyc, stall_left, delay_cur, resp_wait, idx;
        bit pend, in_req;
        logic [31:0]  req_addr;
        logic [255:0] pend_beat;
        obs_addr.delete();
        extra_stall = 0; addr_glitch = 0; timed_out = 0; aborted = 0;
        req_addr = '0; pend_beat = '0;
        @(negedge clk);
        w_addr = wa; x_addr = xa; k_dim = kd; x_stride = xs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_after_start = done;
        w_addr = $urandom; x_addr = $urandom; k_dim = $urandom; x_stride = $urandom;
        cyc = 0; pend = 0; in_req = 0; idx = 0; resp_wait = 0;
        stall_left = first_stall; delay_cur = first_delay;
        while (cyc < 3000) begin
            if (done) break;
            if (reset_mid && idx >= 4 && en) begin
                reset = 1'b1;
                @(negedge clk);
                mid_busy = busy; mid_re = dma_re; mid_en = en;
                reset = 1'b0; aborted = 1;
                dma_req_ready = 1'b0; dma_resp_valid = 1'b0;
                return;
            end
            start = poke_start && (cyc == 5);
            dma_resp_valid = 1'b0;
            if (pend) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    dma_resp_valid = 1'b1; dma_rdata = pend_beat; pend = 0;
                end
            end
            dma_req_ready = 1'b0;
            if (dma_re) begin
                if (!in_req) begin
                    in_req = 1; req_addr = dma_addr;
                end else if (dma_addr !== req_addr) begin
                    addr_glitch++;
                end
                if (stall_left > 0) begin
                    stall_left--; extra_stall++;
                end else begin
                    dma_req_ready = 1'b1; in_req = 0;
                    obs_addr.push_back(dma_addr);
                    pend = 1; resp_wait = delay_cur; extra_stall += delay_cur - 1;
                    pend_beat = make_beat(idx % 2 == 0, idx / 2);
                    idx++;
                    stall_left = rand_dma ? int'($urandom_range(3)) : 0;
                    delay_cur  = rand_dma ? int'($urandom_range(1, 3)) : 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; dma_req_ready = 1'b0; dma_resp_valid = 1'b0;
        timed_out = !done;
        $display("run k_dim=%0d reqs=%0d busy_cycles=%0d stall_cycles=%0d done=%0b",
                 kd, obs_addr.size(), busy_cycles, stall_cycles, done);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, dma_re, en, clear_acc} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, dma_re, en, clear_acc});
        end
        vectors++;
        if ({a_left, b_top} !== 128'b0 || dma_addr !== 32'b0) begin
            miscompares++;
            $display("FAIL reset_data a_left=%h b_top=%h dma_addr=%h want 0", a_left, b_top, dma_addr);
        end
        vectors++;
        if ({busy_cycles, compute_cycles, stall_cycles, dma_req_count} !== 128'b0) begin
            miscompares++;
            $display("FAIL reset_perf got %h want 0", {busy_cycles, compute_cycles, stall_cycles, dma_req_count});
        end
    endtask

    task automatic test_identity();
        fill_random();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                wm[r][k] = (r == k) ? 1 : 0;
                xm[k][r] = k*4 + r + 1;
            end
        run_job(4, 32'h1000, 32'h2000, 32'h20, 0, 1, 0, 0, 0);
        vectors++;
        if (timed_out || done_after_start !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL identity_handshake timeout=%0b done_after_start=%0b busy=%0b want 0 0 0", timed_out, done_after_start, busy);
        end
        vectors++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 32'h1000 || obs_addr[1] !== 32'h2000) begin
            miscompares++;
            $display("FAIL identity_addrs got %p want '{1000,2000}", obs_addr);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (acc[i][j] !== longint'(i*4 + j + 1)) begin
                    miscompares++;
                    $display("FAIL identity_c[%0d][%0d] got %0d want %0d", i, j, acc[i][j], i*4 + j + 1);
                end
            end
        vectors++;
        if (busy_cycles !== 32'd17 || dma_req_count !== 32'd2 || compute_cycles !== 32'd4 || stall_cycles !== 32'd4) begin
            miscompares++;
            $display("FAIL identity_perf busy=%0d req=%0d comp=%0d stall=%0d want 17 2 4 4", busy_cycles, dma_req_count, compute_cycles, stall_cycles);
        end
    endtask

    task automatic test_masked_tail();
        fill_random();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 6; k++) begin
                wm[r][k] = 1; xm[k][r] = 1;
            end
        run_job(6, 32'h0000_4000, 32'h0000_8000, 32'h40, 0, 1, 0, 0, 0);
        vectors++;
        if (obs_addr.size() != 4 || obs_addr[0] !== 32'h4000 || obs_addr[1] !== 32'h8000 ||
            obs_addr[2] !== 32'h4020 || obs_addr[3] !== 32'h8040) begin
            miscompares++;
            $display("FAIL masked_addrs got %p want '{4000,8000,4020,8040}", obs_addr);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (acc[i][j] !== 64'sd6) begin
                    miscompares++;
                    $display("FAIL masked_c[%0d][%0d] got %0d want 6", i, j, acc[i][j]);
                end
            end
        vectors++;
        if (timed_out || busy_cycles !== 32'd25 || dma_req_count !== 32'd4) begin
            miscompares++;
            $display("FAIL masked_perf timeout=%0b busy=%0d req=%0d want 0 25 4", timed_out, busy_cycles, dma_req_count);
        end
    endtask

    task automatic test_dma_stall();
        fill_random();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                wm[r][k] = (r == k) ? 1 : 0;
                xm[k][r] = k*4 + r + 1;
            end
        run_job(4, 32'h1000, 32'h2000, 32'h20, 5, 3, 0, 0, 0);
        vectors++;
        if (addr_glitch != 0 || obs_addr.size() != 2 || obs_addr[0] !== 32'h1000) begin
            miscompares++;
            $display("FAIL stall_addr glitches=%0d reqs=%0d first=%h want 0 2 1000", addr_glitch, obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 32'h0);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (acc[i][j] !== longint'(i*4 + j + 1)) begin
                    miscompares++;
                    $display("FAIL stall_c[%0d][%0d] got %0d want %0d", i, j, acc[i][j], i*4 + j + 1);
                end
            end
        vectors++;
        if (timed_out || stall_cycles !== 32'd11 || busy_cycles !== 32'd24) begin
            miscompares++;
            $display("FAIL stall_perf timeout=%0b stall=%0d busy=%0d want 0 11 24", timed_out, stall_cycles, busy_cycles);
        end
    endtask

    task automatic test_zero_k();
        fill_random();
        run_job(0, 32'h1000, 32'h2000, 32'h20, 0, 1, 0, 0, 0);
        vectors++;
        if (timed_out || obs_addr.size() != 0 || busy_cycles !== 32'd2 || dma_req_count !== 32'd0) begin
            miscompares++;
            $display("FAIL zero_k timeout=%0b reqs=%0d busy=%0d req_count=%0d want 0 0 2 0", timed_out, obs_addr.size(), busy_cycles, dma_req_count);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (acc[i][j] !== 64'sd0) begin
                    miscompares++;
                    $display("FAIL zero_k_c[%0d][%0d] got %0d want 0", i, j, acc[i][j]);
                end
            end
    endtask

    task automatic test_ignored_inputs();
        fill_random();
        @(negedge clk);
        dma_resp_valid = 1'b1; dma_rdata = {8{$urandom}};
        @(negedge clk);
        dma_resp_valid = 1'b0;
        run_job(7, 32'h0001_0000, 32'h0002_0000, 32'h100, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (acc[i][j] !== exp_c(i, j, 7)) begin
                    miscompares++;
                    $display("FAIL ignore_c[%0d][%0d] got %0d want %0d", i, j, acc[i][j], exp_c(i, j, 7));
                end
            end
        vectors++;
        if (timed_out || busy_cycles !== 32'd25 || dma_req_count !== 32'd4 || compute_cycles !== 32'd8) begin
            miscompares++;
            $display("FAIL ignore_perf timeout=%0b busy=%0d req=%0d comp=%0d want 0 25 4 8", timed_out, busy_cycles, dma_req_count, compute_cycles);
        end
    endtask

    task automatic test_reset_mid_run();
        fill_random();
        run_job(8, 32'h3000, 32'h5000, 32'h20, 0, 1, 0, 0, 1);
        vectors++;
        if (aborted !== 1'b1 || {mid_busy, mid_re, mid_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid aborted=%0b busy/re/en=%b want 1 000", aborted, {mid_busy, mid_re, mid_en});
        end
        fill_random();
        run_job(5, 32'h3000, 32'h5000, 32'h20, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (acc[i][j] !== exp_c(i, j, 5)) begin
                    miscompares++;
                    $display("FAIL after_reset_c[%0d][%0d] got %0d want %0d", i, j, acc[i][j], exp_c(i, j, 5));
                end
            end
        vectors++;
        if (timed_out || busy_cycles !== 32'd25) begin
            miscompares++;
            $display("FAIL after_reset_perf timeout=%0b busy=%0d want 0 25", timed_out, busy_cycles);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int kd, kb;
            logic [31:0] wa, xa, xs, ea;
            kd = int'($urandom_range(1, 16));
            kb = (kd + 3) / 4;
            wa = (n == 0) ? 32'hFFFF_FFC0 : $urandom;
            xa = $urandom;
            xs = $urandom;
            fill_random();
            run_job(kd, wa, xa, xs, int'($urandom_range(3)), int'($urandom_range(1, 3)), 1, 0, 0);
            vectors++;
            if (timed_out || obs_addr.size() != 2*kb || addr_glitch != 0) begin
                miscompares++;
                $display("FAIL rand%0d_reqs timeout=%0b reqs=%0d glitches=%0d want 0 %0d 0", n, timed_out, obs_addr.size(), addr_glitch, 2*kb);
            end
            for (int q = 0; q < obs_addr.size() && q < 2*kb; q++) begin
                ea = (q % 2 == 0) ? wa + 32'(32 * (q / 2)) : xa + 32'(q / 2) * xs;
                vectors++;
                if (obs_addr[q] !== ea) begin
                    miscompares++;
                    $display("FAIL rand%0d_addr%0d got %h want %h", n, q, obs_addr[q], ea);
                end
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    vectors++;
                    if (acc[i][j] !== exp_c(i, j, kd)) begin
                        miscompares++;
                        $display("FAIL rand%0d_c[%0d][%0d] got %0d want %0d", n, i, j, acc[i][j], exp_c(i, j, kd));
                    end
                end
            vectors++;
            if (busy_cycles !== 32'(exp_busy(kd, extra_stall)) || stall_cycles !== 32'(4*kb + extra_stall) ||
                compute_cycles !== 32'(4*kb) || dma_req_count !== 32'(2*kb)) begin
                miscompares++;
                $display("FAIL rand%0d_perf busy=%0d stall=%0d comp=%0d req=%0d want %0d %0d %0d %0d", n,
                         busy_cycles, stall_cycles, compute_cycles, dma_req_count,
                         exp_busy(kd, extra_stall), 4*kb + extra_stall, 4*kb, 2*kb);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        w_addr = '0; x_addr = '0; k_dim = '0; x_stride = '0;
        dma_req_ready = 1'b0; dma_resp_valid = 1'b0; dma_rdata = '0;
        test_reset();
        test_identity();
        test_masked_tail();
        test_dma_stall();
        test_zero_k();
        test_ignored_inputs();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
